// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the 8-bit system bus.
// Grants are held until slave ack, owner abort, or the BUSY watchdog fires.
module bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  input  logic          i_m0_we,
  input  logic          i_m0_cs,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  input  logic          i_m1_we,
  input  logic          i_m1_cs,
  output logic [DW-1:0] o_m0_dat,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m1_dat,
  output logic          o_m1_ack,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_dat,
  output logic          o_s_we,
  output logic          o_s_cs,
  input  logic [DW-1:0] i_s_dat,
  input  logic          i_s_ack,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          owner_r, owner_s;   // 0 = m0, 1 = m1
  logic          last_r, last_s;
  logic [CW-1:0] wdog_r, wdog_s;
  logic [DW-1:0] m0_dat_r, m0_dat_s, m1_dat_r, m1_dat_s;
  logic          m0_ack_r, m0_ack_s, m1_ack_r, m1_ack_s;
  logic          timeout_r, timeout_s;
  logic          owner_cs_s, pick_s, fire_s;

  // Request selection: a tie goes to the master not granted last
  always_comb begin
    if (i_m0_cs && i_m1_cs) begin
      pick_s = ~last_r;
    end else if (i_m1_cs) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Owner's request line and watchdog expiry in the current BUSY cycle
  always_comb begin
    if (owner_r) begin
      owner_cs_s = i_m1_cs;
    end else begin
      owner_cs_s = i_m0_cs;
    end
    fire_s = WD_EN && (wdog_r == WD_LAST);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    last_s    = last_r;
    wdog_s    = wdog_r;
    m0_dat_s  = m0_dat_r;
    m1_dat_s  = m1_dat_r;
    m0_ack_s  = 1'b0;
    m1_ack_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_m0_cs || i_m1_cs) begin
          state_s = ST_BUSY;
          owner_s = pick_s;
          last_s  = pick_s;
          wdog_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Ack beats both abort and watchdog in the same cycle
        if (i_s_ack) begin
          state_s = ST_DONE;
          if (owner_r) begin
            m1_dat_s = i_s_dat;
            m1_ack_s = 1'b1;
          end else begin
            m0_dat_s = i_s_dat;
            m0_ack_s = 1'b1;
          end
        end else if (!owner_cs_s) begin
          state_s = ST_IDLE;
        end else if (fire_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
          if (owner_r) begin
            m1_dat_s = {DW{1'b1}};
            m1_ack_s = 1'b1;
          end else begin
            m0_dat_s = {DW{1'b1}};
            m0_ack_s = 1'b1;
          end
        end else begin
          if (wdog_r != WD_MAX) begin
            wdog_s = wdog_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            wdog_s = wdog_r;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, owner, watchdog and master-side output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b0;
      wdog_r    <= '0;
      m0_dat_r  <= '0;
      m1_dat_r  <= '0;
      m0_ack_r  <= 1'b0;
      m1_ack_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      wdog_r    <= wdog_s;
      m0_dat_r  <= m0_dat_s;
      m1_dat_r  <= m1_dat_s;
      m0_ack_r  <= m0_ack_s;
      m1_ack_r  <= m1_ack_s;
      timeout_r <= timeout_s;
    end
  end

  // Slave bus driven only from registered state/owner
  always_comb begin
    o_s_addr = '0;
    o_s_dat  = '0;
    o_s_we   = 1'b0;
    o_s_cs   = 1'b0;
    o_grant  = 2'b00;
    if (state_r == ST_BUSY) begin
      o_s_cs = 1'b1;
      if (owner_r) begin
        o_s_addr = i_m1_addr;
        o_s_dat  = i_m1_dat;
        o_s_we   = i_m1_we;
        o_grant  = 2'b10;
      end else begin
        o_s_addr = i_m0_addr;
        o_s_dat  = i_m0_dat;
        o_s_we   = i_m0_we;
        o_grant  = 2'b01;
      end
    end else begin
      o_grant = 2'b00;
    end
  end

  assign o_m0_dat  = m0_dat_r;
  assign o_m1_dat  = m1_dat_r;
  assign o_m0_ack  = m0_ack_r;
  assign o_m1_ack  = m1_ack_r;
  assign o_timeout = timeout_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corner cases,
// and random traffic against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int T = 4;

  logic        i_clk, i_reset;
  logic [15:0] m_addr[2];
  logic [7:0]  m_dat[2];
  logic        m_we[2], m_cs[2];
  logic [7:0]  s_rdat;
  logic        s_ack;
  logic [7:0]  o_m0_dat, o_m1_dat, o_s_dat;
  logic        o_m0_ack, o_m1_ack, o_s_we, o_s_cs, o_timeout;
  logic [15:0] o_s_addr;
  logic [1:0]  o_grant;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.AW(16), .DW(8), .TIMEOUT(T)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_addr(m_addr[0]), .i_m0_dat(m_dat[0]), .i_m0_we(m_we[0]), .i_m0_cs(m_cs[0]),
    .i_m1_addr(m_addr[1]), .i_m1_dat(m_dat[1]), .i_m1_we(m_we[1]), .i_m1_cs(m_cs[1]),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
    .o_s_addr(o_s_addr), .o_s_dat(o_s_dat), .o_s_we(o_s_we), .o_s_cs(o_s_cs),
    .i_s_dat(s_rdat), .i_s_ack(s_ack), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         c0, c1, ack;
    logic [7:0] sd;
    bit         e_cs;
    logic [1:0] e_gr;
    bit         e_a0, e_a1;
    logic [7:0] e_sd, e_d0, e_d1;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input bit c0, c1, ack, input logic [7:0] sd, input bit e_cs,
                     input logic [1:0] e_gr, input bit e_a0, e_a1,
                     input logic [7:0] e_sd, e_d0, e_d1);
    vecs.push_back('{c0, c1, ack, sd, e_cs, e_gr, e_a0, e_a1, e_sd, e_d0, e_d1});
  endtask

  task automatic new_req(input int m);
    m_cs[m]   = 1'b1;
    m_addr[m] = 16'($urandom);
    m_dat[m]  = 8'($urandom);
    m_we[m]   = 1'($urandom);
  endtask

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    m_cs[0] = 1'b0; m_cs[1] = 1'b0; s_ack = 1'b0; s_rdat = 8'h00;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  // Reference model: transaction-level view of who is being served
  int         md, own, last, served;   // md: 0 free, 1 serving, 2 finishing
  logic [7:0] mdat[2];
  bit         mack[2];
  bit         mto;

  task automatic model_step();
    bit nack[2];
    bit nto;
    nack[0] = 1'b0; nack[1] = 1'b0; nto = 1'b0;
    if (md == 0) begin
      if (m_cs[0] || m_cs[1]) begin
        own    = (m_cs[0] && m_cs[1]) ? 1 - last : (m_cs[1] ? 1 : 0);
        last   = own;
        md     = 1;
        served = 0;
      end
    end else if (md == 1) begin
      served++;
      if (s_ack) begin
        mdat[own] = s_rdat; nack[own] = 1'b1; md = 2;
      end else if (!m_cs[own]) begin
        md = 0;
      end else if (served == T) begin
        mdat[own] = 8'hFF; nack[own] = 1'b1; nto = 1'b1; md = 2;
      end
    end else begin
      md = 0;
    end
    mack[0] = nack[0]; mack[1] = nack[1]; mto = nto;
  endtask

  initial begin
    logic [15:0] e_addr;
    i_reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_cs[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = 16'h0000; m_dat[m] = 8'h00;
    end
    s_ack = 1'b0; s_rdat = 8'h00;

    // c0 c1 ack sd | cs grant a0 a1 s_dat dat0 dat1
    add(1,1,0,8'h00, 0,2'b00,0,0,8'h00, 8'h00,8'h00);
    add(1,1,1,8'hA1, 1,2'b10,0,0,8'h22, 8'h00,8'h00);
    add(1,1,0,8'h00, 0,2'b00,0,1,8'h00, 8'h00,8'hA1);
    add(1,1,0,8'h00, 0,2'b00,0,0,8'h00, 8'h00,8'hA1);
    add(1,1,1,8'hB2, 1,2'b01,0,0,8'h11, 8'h00,8'hA1);
    add(1,1,0,8'h00, 0,2'b00,1,0,8'h00, 8'hB2,8'hA1);
    add(1,1,0,8'h00, 0,2'b00,0,0,8'h00, 8'hB2,8'hA1);
    add(1,1,1,8'hC3, 1,2'b10,0,0,8'h22, 8'hB2,8'hA1);
    add(1,1,0,8'h00, 0,2'b00,0,1,8'h00, 8'hB2,8'hC3);
    add(1,1,0,8'h00, 0,2'b00,0,0,8'h00, 8'hB2,8'hC3);
    add(1,1,0,8'h00, 1,2'b01,0,0,8'h11, 8'hB2,8'hC3);
    add(1,1,1,8'hD4, 1,2'b01,0,0,8'h11, 8'hB2,8'hC3);
    add(1,1,0,8'h00, 0,2'b00,1,0,8'h00, 8'hD4,8'hC3);
    add(1,1,0,8'h00, 0,2'b00,0,0,8'h00, 8'hD4,8'hC3);
    add(1,1,1,8'hE5, 1,2'b10,0,0,8'h22, 8'hD4,8'hC3);
    add(1,1,0,8'h00, 0,2'b00,0,1,8'h00, 8'hD4,8'hE5);
    add(1,1,0,8'h00, 0,2'b00,0,0,8'h00, 8'hD4,8'hE5);
    add(1,1,1,8'hF6, 1,2'b01,0,0,8'h11, 8'hD4,8'hE5);
    add(0,0,0,8'h00, 0,2'b00,1,0,8'h00, 8'hF6,8'hE5);
    add(0,0,0,8'h00, 0,2'b00,0,0,8'h00, 8'hF6,8'hE5);

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_cs", {31'd0, o_s_cs}, 32'd0);
    chk("rst_grant", {30'd0, o_grant}, 32'd0);
    chk("rst_acks", {29'd0, o_m0_ack, o_m1_ack, o_timeout}, 32'd0);
    chk("rst_dat", {16'd0, o_m0_dat, o_m1_dat}, 32'd0);
    i_reset = 1'b1;

    // Tie after reset, then continuous alternating requests
    m_addr[0] = 16'h0010; m_dat[0] = 8'h11; m_we[0] = 1'b1;
    m_addr[1] = 16'h0020; m_dat[1] = 8'h22; m_we[1] = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      cyc();
      m_cs[0] = vecs[i].c0; m_cs[1] = vecs[i].c1;
      s_ack = vecs[i].ack; s_rdat = vecs[i].sd;
      @(negedge i_clk);
      e_addr = (vecs[i].e_gr == 2'b10) ? 16'h0020 : (vecs[i].e_gr == 2'b01) ? 16'h0010 : 16'h0000;
      chk($sformatf("vec%0d_cs", i), {31'd0, o_s_cs}, {31'd0, vecs[i].e_cs});
      chk($sformatf("vec%0d_grant", i), {30'd0, o_grant}, {30'd0, vecs[i].e_gr});
      chk($sformatf("vec%0d_acks", i), {30'd0, o_m0_ack, o_m1_ack}, {30'd0, vecs[i].e_a0, vecs[i].e_a1});
      chk($sformatf("vec%0d_sbus", i), {7'd0, o_s_we, o_s_addr, o_s_dat},
          {7'd0, |vecs[i].e_gr, e_addr, vecs[i].e_sd});
      chk($sformatf("vec%0d_mdat", i), {16'd0, o_m0_dat, o_m1_dat}, {16'd0, vecs[i].e_d0, vecs[i].e_d1});
      chk($sformatf("vec%0d_to", i), {31'd0, o_timeout}, 32'd0);
    end
    s_ack = 1'b0;

    // m0 read at 0x1234 with registered-ack slave
    cyc(); m_cs[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 16'h1234;
    @(negedge i_clk); chk("rd_c_cs", {31'd0, o_s_cs}, 32'd0);
    cyc(); @(negedge i_clk);
    chk("rd_c1_cs", {31'd0, o_s_cs}, 32'd1);
    chk("rd_c1_grant", {30'd0, o_grant}, 32'd1);
    chk("rd_c1_addr", {15'd0, o_s_we, o_s_addr}, {16'd0, 16'h1234});
    cyc(); s_ack = 1'b1; s_rdat = 8'h5A;
    @(negedge i_clk); chk("rd_c2_cs", {31'd0, o_s_cs}, 32'd1);
    cyc(); s_ack = 1'b0; m_cs[0] = 1'b0;
    @(negedge i_clk);
    chk("rd_c3_ack", {30'd0, o_m0_ack, o_m1_ack}, 32'd2);
    chk("rd_c3_dat", {24'd0, o_m0_dat}, 32'h5A);
    chk("rd_c3_cs", {31'd0, o_s_cs}, 32'd0);

    // Watchdog: no ack, then ack in the final BUSY cycle
    for (int rep = 0; rep < 2; rep++) begin
      cyc(); m_cs[0] = 1'b1; m_addr[0] = 16'h0300;
      @(negedge i_clk);
      for (int k = 1; k <= T; k++) begin
        cyc();
        if (rep == 1 && k == T) begin s_ack = 1'b1; s_rdat = 8'h3C; end
        @(negedge i_clk);
        chk($sformatf("wd%0d_busy%0d", rep, k), {30'd0, o_s_cs, o_m0_ack}, 32'd2);
      end
      cyc(); s_ack = 1'b0; m_cs[0] = 1'b0;
      @(negedge i_clk);
      chk($sformatf("wd%0d_ack", rep), {31'd0, o_m0_ack}, 32'd1);
      chk($sformatf("wd%0d_dat", rep), {24'd0, o_m0_dat}, (rep == 0) ? 32'hFF : 32'h3C);
      chk($sformatf("wd%0d_to", rep), {31'd0, o_timeout}, (rep == 0) ? 32'd1 : 32'd0);
      cyc(); @(negedge i_clk);
      chk($sformatf("wd%0d_idle", rep), {29'd0, o_s_cs, o_timeout, o_m0_ack}, 32'd0);
    end

    // m1 aborts in its second BUSY cycle
    cyc(); m_cs[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 16'h0400;
    @(negedge i_clk);
    cyc(); @(negedge i_clk);
    chk("ab_grant", {30'd0, o_grant}, 32'd2);
    cyc(); m_cs[1] = 1'b0;
    @(negedge i_clk); chk("ab_busy2", {31'd0, o_s_cs}, 32'd1);
    cyc(); @(negedge i_clk);
    chk("ab_after", {30'd0, o_s_cs, o_m1_ack}, 32'd0);
    chk("ab_dat", {24'd0, o_m1_dat}, 32'hE5);
    cyc(); @(negedge i_clk);
    chk("ab_noack", {31'd0, o_m1_ack}, 32'd0);

    // Asynchronous reset mid-BUSY, then a pending tie grants m1
    cyc(); m_cs[0] = 1'b1; m_addr[0] = 16'h0500;
    cyc(); @(negedge i_clk);
    chk("ar_busy", {31'd0, o_s_cs}, 32'd1);
    #2; i_reset = 1'b0; m_cs[1] = 1'b1;
    #1;
    chk("ar_cs_grant", {29'd0, o_s_cs, o_grant}, 32'd0);
    chk("ar_sbus", {7'd0, o_s_we, o_s_addr, o_s_dat}, 32'd0);
    chk("ar_flags", {29'd0, o_m0_ack, o_m1_ack, o_timeout}, 32'd0);
    chk("ar_dat", {16'd0, o_m0_dat, o_m1_dat}, 32'd0);
    @(posedge i_clk); @(negedge i_clk); #2; i_reset = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    chk("ar_tie", {29'd0, o_s_cs, o_grant}, 32'h6);

    // Random traffic against the reference model
    do_reset();
    md = 0; own = 0; last = 0; served = 0; mto = 1'b0;
    for (int m = 0; m < 2; m++) begin mdat[m] = 8'h00; mack[m] = 1'b0; end
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] ea;
      logic [7:0]  ed;
      logic        ew;
      cyc();
      for (int m = 0; m < 2; m++) begin
        if (m_cs[m]) begin
          if (mack[m]) begin
            if ($urandom_range(1, 0) == 1) new_req(m); else m_cs[m] = 1'b0;
          end else if ($urandom_range(15, 0) == 0) begin
            m_cs[m] = 1'b0;
          end
        end else if ($urandom_range(1, 0) == 1) begin
          new_req(m);
        end
      end
      @(negedge i_clk);
      ea = (md == 1) ? m_addr[own] : 16'h0000;
      ed = (md == 1) ? m_dat[own] : 8'h00;
      ew = (md == 1) ? m_we[own] : 1'b0;
      chk("rnd_cs", {31'd0, o_s_cs}, {31'd0, md == 1});
      chk("rnd_grant", {30'd0, o_grant}, (md == 1) ? ((own == 1) ? 32'd2 : 32'd1) : 32'd0);
      chk("rnd_sbus", {7'd0, o_s_we, o_s_addr, o_s_dat}, {7'd0, ew, ea, ed});
      chk("rnd_ack", {29'd0, o_m0_ack, o_m1_ack, o_timeout}, {29'd0, mack[0], mack[1], mto});
      chk("rnd_dat", {16'd0, o_m0_dat, o_m1_dat}, {16'd0, mdat[0], mdat[1]});
      s_rdat = 8'($urandom);
      s_ack  = (md == 1) && ($urandom_range(2, 0) == 0);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the 8-bit system bus. It merges the debug master port of the UART master/slave block (m1) with the CPU bus master (m0) onto a single slave bus feeding RAM and peripherals. Requests are granted round-robin, and each grant is held until the slave acknowledges. A watchdog terminates any transaction whose slave never acknowledges, so a wedged peripheral cannot lock out the UART debug path.

## Interface
Parameters:
- AW, 16, address width
- DW, 8, data width
- TIMEOUT, 255, max BUSY cycles before forced termination; 0 disables the watchdog

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_m0_addr / i_m1_addr  in  AW  master address
- i_m0_dat / i_m1_dat  in  DW  master write data
- i_m0_we / i_m1_we  in  1  write enable
- i_m0_cs / i_m1_cs  in  1  request; held with addr/dat/we stable until ack
- o_m0_dat / o_m1_dat  out  DW  read data returned to the master, registered
- o_m0_ack / o_m1_ack  out  1  one-cycle completion pulse
- o_s_addr  out  AW  slave address
- o_s_dat  out  DW  slave write data
- o_s_we  out  1  slave write enable
- o_s_cs  out  1  slave chip select
- i_s_dat  in  DW  slave read data
- i_s_ack  in  1  slave acknowledge; may arrive combinationally in the first cs cycle, or later
- o_grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1
- o_timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- States:
  - IDLE: o_s_cs=0.
  - BUSY: o_s_cs=1; the owner's addr/dat/we are muxed to the slave bus.
  - DONE: o_s_cs=0; one turnaround cycle in which the master ack is presented.
- IDLE → BUSY when either cs is high.
  - Only one requester: grant it.
  - Both requesting: grant the master not granted last.
  - The owner register and the last-grant pointer update on this edge.
- BUSY, i_s_ack=1 → DONE:
  - o_mX_dat <= i_s_dat for the owner only, captured on writes too.
  - o_mX_ack <= 1 for the owner.
- BUSY, owner cs drops without ack (abort) → IDLE. No master ack is issued; o_mX_dat is unchanged.
- BUSY, watchdog: with TIMEOUT≠0, a counter of BUSY cycles is kept.
  - If the TIMEOUT-th BUSY cycle passes with no ack → DONE.
  - Owner ack=1, o_mX_dat <= {DW{1'b1}}, o_timeout=1 for that one cycle.
  - If i_s_ack and the timeout occur in the same cycle, the ack wins: normal data, no o_timeout.
- DONE → IDLE unconditionally. The ack is deasserted in IDLE; a master that keeps cs high is re-arbitrated as a new request.
- Slave bus outside BUSY: o_s_addr, o_s_dat and o_s_we are 0. o_grant is nonzero only in BUSY.
- o_s_* and o_grant are combinational from the registered state/owner only. There is no combinational path from i_mX_cs to o_s_cs.
- Non-owner master: its cs is ignored until IDLE; its ack and data outputs are untouched.

## Timing
- Reset (asynchronous, effective immediately, mid-transaction included):
  - state=IDLE, all outputs 0, o_mX_dat=0, watchdog count=0.
  - Last-grant pointer = m0, so the first tie goes to m1 (UART debug).
- A master raises cs in cycle c.
  - o_s_cs=1 from cycle c+1.
  - A slave ack in cycle k ≥ c+1 gives o_mX_ack=1 and valid o_mX_dat in cycle k+1.
  - The bus returns to IDLE in cycle k+2.
- Throughput:
  - Combinational-ack slave: minimum 3 cycles request-to-request per master; 2-cycle request-to-ack.
  - Registered-ack slave (ack one cycle after cs): 3-cycle request-to-ack.
- A competing master waiting in IDLE at cycle k+2 sees o_s_cs=1 in k+3.
- Watchdog counter:
  - Width $clog2(TIMEOUT+1); cleared on IDLE→BUSY.
  - Increments each BUSY cycle and never wraps.
  - With TIMEOUT=T and no ack, the master ack occurs in cycle c+T+1.

## Test plan
- m0 read at 0x1234, slave acks 1 cycle after cs with 0x5A: o_s_cs high for cycles c+1 and c+2, o_m0_ack=1 in c+3 with o_m0_dat=0x5A, o_grant=01 during BUSY.
- Both masters raise cs in the same cycle after reset, m0 writing 0x11 to 0x0010 and m1 writing 0x22 to 0x0020:
  - m1 is served first, then m0.
  - o_s_dat shows 0x22 then 0x11.
  - No overlap of o_s_cs between the two grants.
  - Each ack appears only at its own master.
- m0 and m1 both hold continuous requests for 6 transactions: grants strictly alternate m1, m0, m1, …, with one IDLE and one DONE cycle between grants.
- TIMEOUT=4, slave never acks, m0 read: o_m0_ack=1 with o_m0_dat=0xFF and o_timeout=1 in cycle c+5; next state is IDLE. Repeat with the ack arriving in the 4th BUSY cycle: normal data, o_timeout stays 0.
- Abort and reset:
  - m1 drops cs in its 2nd BUSY cycle with no ack: no o_m1_ack, o_s_cs=0 the next cycle.
  - Assert i_reset low mid-BUSY: all outputs 0 immediately, with no clock edge required.
  - After release, a pending tie grants m1.
